rv_mem_arb: RTL and testbench

//  Arbitrates one single-port unified memory between the instruction-fetch port and the data port of the

---
 rtl/rv_mem_arb.sv | 169 ++++++++++++++++
 tb/tb_rv_mem_arb.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_mem_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : rv_mem_arb                                                      |
// | Shares one single-port memory between the instruction-fetch port and the |
// | data port of the multicycle RV core. Data has priority; fetch is forced  |
// | through after STARVE_LIM consecutive conflicting data grants.            |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module rv_mem_arb #(
  parameter int DPWIDTH    = 32,
  parameter int MEMLAT     = 1,
  parameter int STARVE_LIM = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               if_req,
  input  logic [DPWIDTH-1:0] if_addr,
  output logic               if_ack,
  output logic [DPWIDTH-1:0] if_rdata,
  input  logic               d_req,
  input  logic               d_we,
  input  logic [DPWIDTH-1:0] d_addr,
  input  logic [DPWIDTH-1:0] d_wdata,
  output logic               d_ack,
  output logic [DPWIDTH-1:0] d_rdata,
  output logic               mem_en,
  output logic               mem_we,
  output logic [DPWIDTH-1:0] mem_addr,
  output logic [DPWIDTH-1:0] mem_wdata,
  input  logic [DPWIDTH-1:0] mem_rdata,
  output logic               busy
);

  localparam int CNT_W = (STARVE_LIM > 0) ? $clog2(STARVE_LIM + 1) : 1;
  localparam int LAT_W = (MEMLAT > 1) ? $clog2(MEMLAT) : 1;
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIM);
  localparam logic [LAT_W-1:0] LAT_LAST   = LAT_W'(MEMLAT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic                 owner_q, owner_d;      // 1 = data port owns the access
  logic [CNT_W-1:0]     starve_q, starve_d;    // consecutive conflicting data grants
  logic [LAT_W-1:0]     lat_q, lat_d;          // remaining WAIT cycles minus one
  logic                 mem_en_q, mem_en_d;
  logic                 mem_we_q, mem_we_d;
  logic [DPWIDTH-1:0]   mem_addr_q, mem_addr_d;    // doubles as the address latch
  logic [DPWIDTH-1:0]   mem_wdata_q, mem_wdata_d;  // doubles as the write-data latch
  logic                 if_ack_q, if_ack_d;
  logic                 d_ack_q, d_ack_d;
  logic [DPWIDTH-1:0]   if_rdata_q, if_rdata_d;
  logic [DPWIDTH-1:0]   d_rdata_q, d_rdata_d;
  logic                 w_grant_data;

  // Next-state, arbitration and registered-output logic
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    starve_d     = starve_q;
    lat_d        = lat_q;
    mem_en_d     = 1'b0;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    if_ack_d     = 1'b0;
    d_ack_d      = 1'b0;
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;
    w_grant_data = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Data wins unless fetch is also waiting and has been passed over
        // STARVE_LIM times in a row.
        w_grant_data = d_req && (!if_req || (starve_q != STARVE_MAX));
        if (if_req || d_req) begin
          state_d  = S_ACCESS;
          mem_en_d = 1'b1;
          if (w_grant_data) begin
            owner_d     = 1'b1;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
            mem_we_d    = d_we;
            if (if_req) begin
              starve_d = starve_q + CNT_W'(1);
            end
          end else begin
            owner_d    = 1'b0;
            mem_addr_d = if_addr;
            starve_d   = '0;
          end
        end
      end
      S_ACCESS: begin
        state_d = S_WAIT;
        lat_d   = LAT_LAST;
      end
      S_WAIT: begin
        if (lat_q == '0) begin
          // Read data is valid in this last WAIT cycle; writes capture too.
          state_d = S_RESP;
          if (owner_q) begin
            d_rdata_d = mem_rdata;
            d_ack_d   = 1'b1;
          end else begin
            if_rdata_d = mem_rdata;
            if_ack_d   = 1'b1;
          end
        end else begin
          lat_d = lat_q - LAT_W'(1);
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      owner_q     <= 1'b0;
      starve_q    <= '0;
      lat_q       <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      starve_q    <= starve_d;
      lat_q       <= lat_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_ack_q    <= if_ack_d;
      d_ack_q     <= d_ack_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign if_ack    = if_ack_q;
  assign if_rdata  = if_rdata_q;
  assign d_ack     = d_ack_q;
  assign d_rdata   = d_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_rv_mem_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : tb_rv_mem_arb                                                   |
// | Bench for rv_mem_arb: one instance at MEMLAT=1/STARVE_LIM=2 and one at   |
// | MEMLAT=3/STARVE_LIM=0 sharing the requester inputs.                      |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module tb_rv_mem_arb;

  localparam int W     = 32;
  localparam int LAT1  = 1;
  localparam int SLIM1 = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         if_req, d_req, d_we;
  logic [W-1:0] if_addr, d_addr, d_wdata;

  logic         if_ack, d_ack, mem_en, mem_we, busy;
  logic [W-1:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic         if_ack_3, d_ack_3, mem_en_3, mem_we_3, busy_3;
  logic [W-1:0] if_rdata_3, d_rdata_3, mem_addr_3, mem_wdata_3, mem_rdata_3;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rv_mem_arb #(.DPWIDTH(W), .MEMLAT(LAT1), .STARVE_LIM(SLIM1)) u_dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  rv_mem_arb #(.DPWIDTH(W), .MEMLAT(3), .STARVE_LIM(0)) u_dut3 (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack_3), .if_rdata(if_rdata_3),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack_3), .d_rdata(d_rdata_3),
    .mem_en(mem_en_3), .mem_we(mem_we_3), .mem_addr(mem_addr_3), .mem_wdata(mem_wdata_3),
    .mem_rdata(mem_rdata_3), .busy(busy_3)
  );

  // Initial memory image: distinct word per low address byte
  function automatic logic [W-1:0] init_val(input logic [7:0] a);
    return {a, ~a, a ^ 8'h5A, 8'hC3};
  endfunction

  // Memory behind the MEMLAT=1 instance; off-cycle data is a poison value
  logic [W-1:0] mem1 [256];
  logic [W-1:0] rd1;
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem1[i] <= init_val(8'(i));
      rd1 <= 32'hBAD0_0001;
    end else begin
      rd1 <= mem_en ? mem1[mem_addr[7:0]] : 32'hBAD0_0001;
      if (mem_en && mem_we) mem1[mem_addr[7:0]] <= mem_wdata;
    end
  end
  assign mem_rdata = rd1;

  // Memory behind the MEMLAT=3 instance: three-stage read pipeline
  logic [W-1:0] mem3 [256];
  logic [W-1:0] p3 [3];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem3[i] <= init_val(8'(i));
      for (int i = 0; i < 3; i++) p3[i] <= 32'hBAD0_0003;
    end else begin
      p3[0] <= mem_en_3 ? mem3[mem_addr_3[7:0]] : 32'hBAD0_0003;
      p3[1] <= p3[0];
      p3[2] <= p3[1];
      if (mem_en_3 && mem_we_3) mem3[mem_addr_3[7:0]] <= mem_wdata_3;
    end
  end
  assign mem_rdata_3 = p3[2];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [W-1:0] got, input logic [W-1:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, got, want);
    end
  endtask

  task automatic chk_zero(input string nm, input logic [4:0] flags, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] c, input logic [W-1:0] d);
    chk({nm, "_flags"}, {27'd0, flags}, 32'd0);
    chk({nm, "_maddr"}, a, 32'd0);
    chk({nm, "_mwdata"}, b, 32'd0);
    chk({nm, "_ifrd"}, c, 32'd0);
    chk({nm, "_drd"}, d, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [W-1:0] rand_addr();
    logic [W-1:0] a;
    a      = $urandom;
    a[7:0] = 8'($urandom_range(0, 15));
    return a;
  endfunction

  typedef struct {
    logic         ireq, dreq, dwe;
    logic [W-1:0] iaddr, daddr, dwdata;
    logic         exp_data;
    logic [W-1:0] exp_addr, exp_rdata;
  } vec_t;

  vec_t         vecs [12];
  logic [W-1:0] last_if;

  // random-phase reference model state
  logic [W-1:0] ref_mem [256];
  bit           act, o_d, o_we, ip, dp;
  int           g, next_free, starve, consec;
  logic [W-1:0] o_addr, o_wdata, o_rd;
  bit           e_en, e_resp, prev_en;

  initial begin
    // isolated transactions from IDLE: {ireq,dreq,dwe,iaddr,daddr,dwdata,exp_data,exp_addr,exp_rdata}
    vecs[0]  = '{1'b0, 1'b1, 1'b1, 32'h0,  32'h10, 32'hDEADBEEF, 1'b1, 32'h10, 32'h0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 32'h10, 32'h0,  32'h0,        1'b0, 32'h10, 32'hDEADBEEF};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 32'h0,  32'h8,  32'h1234,     1'b1, 32'h8,  32'h0};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 32'h0,  32'h8,  32'h0,        1'b1, 32'h8,  32'h1234};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 32'h40, 32'h20, 32'h0,        1'b1, 32'h20, init_val(8'h20)};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 32'h44, 32'h24, 32'h0,        1'b1, 32'h24, init_val(8'h24)};
    vecs[6]  = '{1'b1, 1'b1, 1'b1, 32'h48, 32'h28, 32'h5555AAAA, 1'b0, 32'h48, init_val(8'h48)};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 32'h4C, 32'h10, 32'h0,        1'b1, 32'h10, 32'hDEADBEEF};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 32'h0,  32'h30, 32'h0,        1'b1, 32'h30, init_val(8'h30)};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 32'h50, 32'h34, 32'h0,        1'b1, 32'h34, init_val(8'h34)};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 32'h54, 32'h38, 32'h0,        1'b0, 32'h54, init_val(8'h54)};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 32'hABCD0058, 32'h0, 32'h0,   1'b0, 32'hABCD0058, init_val(8'h58)};

    rst = 1'b1;
    do_reset();
    chk_zero("rst1", {if_ack, d_ack, mem_en, mem_we, busy}, mem_addr, mem_wdata, if_rdata, d_rdata);
    chk_zero("rst3", {if_ack_3, d_ack_3, mem_en_3, mem_we_3, busy_3},
             mem_addr_3, mem_wdata_3, if_rdata_3, d_rdata_3);

    // MEMLAT=3, STARVE_LIM=0: fetch beats data, ack at cycle 5; reset kills the data access
    if_req = 1'b1; if_addr = 32'h3C; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h22;
    for (int c = 1; c <= 13; c++) begin
      tick();
      chk($sformatf("t5_en_c%0d", c), mem_en_3, (c == 1 || c == 7));
      chk($sformatf("t5_iack_c%0d", c), if_ack_3, (c == 5));
      chk($sformatf("t5_dack_c%0d", c), d_ack_3, 0);
      chk($sformatf("t5_busy_c%0d", c), busy_3, ((c >= 1 && c <= 5) || (c >= 7 && c <= 9)));
      if (c == 1) chk("t5_addr_f", mem_addr_3, 32'h3C);
      if (c == 7) chk("t5_addr_d", mem_addr_3, 32'h22);
      if (c == 5) begin
        chk("t5_ifrd", if_rdata_3, init_val(8'h3C));
        if_req = 1'b0;
      end
      if (c == 9) begin
        rst = 1'b1; d_req = 1'b0;
      end
      if (c == 10) begin
        chk_zero("t5_midrst", {if_ack_3, d_ack_3, mem_en_3, mem_we_3, busy_3},
                 mem_addr_3, mem_wdata_3, if_rdata_3, d_rdata_3);
        rst = 1'b0;
      end
    end

    // table of isolated transactions on the MEMLAT=1 instance
    last_if = '0;
    for (int r = 0; r < 12; r++) begin
      if_req = vecs[r].ireq; d_req = vecs[r].dreq; d_we = vecs[r].dwe;
      if_addr = vecs[r].iaddr; d_addr = vecs[r].daddr; d_wdata = vecs[r].dwdata;
      tick();
      chk($sformatf("v%0d_en", r), mem_en, 1);
      chk($sformatf("v%0d_addr", r), mem_addr, vecs[r].exp_addr);
      chk($sformatf("v%0d_we", r), mem_we, vecs[r].exp_data & vecs[r].dwe);
      if (vecs[r].exp_data && vecs[r].dwe) chk($sformatf("v%0d_wdata", r), mem_wdata, vecs[r].dwdata);
      if_req = 1'b0; d_req = 1'b0;
      tick();
      chk($sformatf("v%0d_wait", r), {mem_en, if_ack, d_ack, busy}, 4'b0001);
      tick();
      chk($sformatf("v%0d_iack", r), if_ack, !vecs[r].exp_data);
      chk($sformatf("v%0d_dack", r), d_ack, vecs[r].exp_data);
      if (!vecs[r].exp_data) last_if = vecs[r].exp_rdata;
      else if (!vecs[r].dwe) chk($sformatf("v%0d_drd", r), d_rdata, vecs[r].exp_rdata);
      chk($sformatf("v%0d_ifrd", r), if_rdata, last_if);
      tick();
      chk($sformatf("v%0d_idle", r), {if_ack, d_ack, busy}, 3'b000);
    end

    // both high: data first, fetch follows once data drops its request
    if_req = 1'b1; if_addr = 32'h40; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
    for (int c = 1; c <= 8; c++) begin
      tick();
      chk($sformatf("t2_en_c%0d", c), mem_en, (c == 1 || c == 5));
      chk($sformatf("t2_dack_c%0d", c), d_ack, (c == 3));
      chk($sformatf("t2_iack_c%0d", c), if_ack, (c == 7));
      if (c == 1) chk("t2_addr_d", mem_addr, 32'h20);
      if (c == 5) chk("t2_addr_f", mem_addr, 32'h40);
      if (c == 3) d_req = 1'b0;
      if (c == 7) if_req = 1'b0;
    end

    // both held continuously: grant order D,D,F,D,D,F
    if_req = 1'b1; if_addr = 32'h60; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h70;
    for (int c = 1; c <= 24; c++) begin
      tick();
      chk($sformatf("t3_en_c%0d", c), mem_en, (c % 4 == 1));
      if (c % 4 == 1)
        chk($sformatf("t3_order%0d", (c - 1) / 4), mem_addr, (((c - 1) / 4) % 3 == 2) ? 32'h60 : 32'h70);
      if (c == 23) begin
        if_req = 1'b0; d_req = 1'b0;
      end
    end

    // fetch-only stream: ack every 4 cycles, mem_en never back-to-back
    if_req = 1'b1; if_addr = 32'h100;
    consec = 0; prev_en = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      tick();
      chk($sformatf("t6_en_c%0d", c), mem_en, (c % 4 == 1));
      chk($sformatf("t6_iack_c%0d", c), if_ack, (c % 4 == 3));
      if (mem_en && prev_en) consec++;
      prev_en = mem_en;
      if (c % 4 == 3) begin
        if_addr = if_addr + 32'd4;
        if (c == 15) if_req = 1'b0;
      end
    end
    chk("t6_consec", consec, 0);

    // randomized traffic against a transaction-level reference
    do_reset();
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(8'(i));
    last_if = '0; act = 1'b0; g = -100; next_free = 0; starve = 0; ip = 1'b0; dp = 1'b0;
    o_d = 1'b0; o_we = 1'b0; o_addr = '0; o_wdata = '0; o_rd = '0;
    for (int k = 0; k < 400; k++) begin
      if (k > 0) tick();
      e_en   = act && (k == g + 1);
      e_resp = act && (k == g + LAT1 + 2);
      if (e_resp && !o_d) last_if = o_rd;
      chk("r_en", mem_en, e_en);
      chk("r_we", mem_we, e_en && o_d && o_we);
      chk("r_busy", busy, act && (k > g));
      chk("r_iack", if_ack, e_resp && !o_d);
      chk("r_dack", d_ack, e_resp && o_d);
      chk("r_ifrd", if_rdata, last_if);
      if (e_en) chk("r_addr", mem_addr, o_addr);
      if (e_en && o_d && o_we) chk("r_wdata", mem_wdata, o_wdata);
      if (e_resp && o_d && !o_we) chk("r_drd", d_rdata, o_rd);
      if (e_resp) begin
        act = 1'b0; next_free = k + 1;
        if (o_d) dp = 1'b0; else ip = 1'b0;
      end
      if (!ip) begin
        if ($urandom_range(0, 2) != 0) begin
          ip = 1'b1; if_req = 1'b1; if_addr = rand_addr();
        end else begin
          if_req = 1'b0;
        end
      end
      if (!dp) begin
        if ($urandom_range(0, 2) != 0) begin
          dp = 1'b1; d_req = 1'b1; d_addr = rand_addr();
          d_we = 1'($urandom_range(0, 1)); d_wdata = $urandom;
        end else begin
          d_req = 1'b0;
        end
      end
      if (!act && k >= next_free && (if_req || d_req)) begin
        o_d = d_req && (!if_req || starve < SLIM1);
        if (o_d && if_req) starve = (starve + 1 > SLIM1) ? SLIM1 : starve + 1;
        if (!o_d) starve = 0;
        o_addr  = o_d ? d_addr : if_addr;
        o_we    = o_d && d_we;
        o_wdata = d_wdata;
        o_rd    = ref_mem[o_addr[7:0]];
        if (o_we) ref_mem[o_addr[7:0]] = o_wdata;
        act = 1'b1; g = k;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
